voice_sched: RTL

Audio-frame scheduler that owns the sample-rate divider and time-shares each sample period among up to NUM_VOICES voice-generator requesters. At every sample tick it latches pending requests, grants them one at a time (round-robin, one-hot) with a grant/done handshake, then pulses `mix_latch` so the mixer/PWM stage registers the completed frame. It sits between the 10 MHz system clock domain and the per-voice synthesis blocks and replaces free-running per-voice sample enables.

---
 rtl/voice_sched_if.sv | 39 +++
 rtl/voice_sched.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_sched_if.sv
// voice_sched_if
//   Bundles the scheduler's request/grant handshake and status lines.
//   master : the scheduler (drives grant and status, receives requests)
//   slave  : the voice side / testbench (drives requests, done, controls)
//   Signals: en, req[NUM_VOICES], done, clear_ovr -> scheduler
//            grant[NUM_VOICES], samp_strobe, mix_latch, busy, overrun <- scheduler
//            timeout <- scheduler (only when SCHED_TIMEOUT_EN is defined)
interface voice_sched_if #(
  parameter int NUM_VOICES = 4
);
  logic                  en;
  logic [NUM_VOICES-1:0] req;
  logic                  done;
  logic                  clear_ovr;
  logic [NUM_VOICES-1:0] grant;
  logic                  samp_strobe;
  logic                  mix_latch;
  logic                  busy;
  logic                  overrun;
`ifdef SCHED_TIMEOUT_EN
  logic                  timeout;
`endif

  modport master (
    input  en, req, done, clear_ovr,
    output grant, samp_strobe, mix_latch, busy, overrun
`ifdef SCHED_TIMEOUT_EN
    , output timeout
`endif
  );

  modport slave (
    output en, req, done, clear_ovr,
    input  grant, samp_strobe, mix_latch, busy, overrun
`ifdef SCHED_TIMEOUT_EN
    , input timeout
`endif
  );
endinterface

// File: rtl/voice_sched.sv
// voice_sched
//   Audio-frame scheduler. Owns the sample-rate divider (period DIV_MAX+1
//   clocks); on every sample tick it latches the pending voice requests,
//   grants them one at a time round-robin with a grant/done handshake and
//   then pulses mix_latch to close the frame.
//   Ports:
//     MHz10 : system clock, rising edge
//     rst   : asynchronous active-high reset
//     bus   : voice_sched_if.master (en, req, done, clear_ovr in;
//             grant, samp_strobe, mix_latch, busy, overrun out)
//   Optional feature macro: SCHED_TIMEOUT_EN adds a SERVE watchdog of
//   TIMEOUT_CYC clocks and the sticky bus.timeout flag.
module voice_sched #(
  parameter int NUM_VOICES = 4,
  parameter int DIV_MAX    = 226,
  parameter int CNT_W      = 8
`ifdef SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic          MHz10,
  input  logic          rst,
  voice_sched_if.master bus
);

  localparam int                    PTR_W    = $clog2(NUM_VOICES);
  localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(DIV_MAX);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(NUM_VOICES - 1);
  localparam logic [PTR_W:0]        NV_EXT   = (PTR_W + 1)'(NUM_VOICES);
  localparam logic [NUM_VOICES-1:0] ONE_HOT0 = {{(NUM_VOICES - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_SERVE = 2'd2,
    S_MIX   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_count;
  logic [NUM_VOICES-1:0] r_pending;
  logic [PTR_W-1:0]      r_rr_ptr;
  logic [PTR_W-1:0]      r_sel;
  logic [NUM_VOICES-1:0] r_grant;
  logic                  r_samp_strobe;
  logic                  r_mix_latch;
  logic                  r_busy;
  logic                  r_overrun;

  logic                  w_tick;
  logic                  w_found;
  logic [PTR_W-1:0]      w_sel;
  logic [PTR_W:0]        w_rr_sum;
  logic [PTR_W-1:0]      w_rr_idx;
  logic                  w_serve_end;
  logic [NUM_VOICES-1:0] w_pending_nxt;
  logic [PTR_W-1:0]      w_rr_nxt;
  logic [PTR_W-1:0]      w_sel_nxt;
  logic [NUM_VOICES-1:0] w_grant_nxt;
  logic                  w_strobe_nxt;
  logic                  w_mix_nxt;
  logic                  w_overrun_nxt;

  assign w_tick = bus.en && (r_count == CNT_MAX);

  // Sample-rate divider: free-runs 0..DIV_MAX while enabled, parked at 0 otherwise.
  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (!bus.en) begin
      r_count <= {CNT_W{1'b0}};
    end else if (r_count == CNT_MAX) begin
      r_count <= {CNT_W{1'b0}};
    end else begin
      r_count <= r_count + {{(CNT_W - 1){1'b0}}, 1'b1};
    end
  end

  // Round-robin search: first pending voice at or above rr_ptr, wrapping.
  always_comb begin
    w_found  = 1'b0;
    w_sel    = {PTR_W{1'b0}};
    w_rr_sum = {(PTR_W + 1){1'b0}};
    w_rr_idx = {PTR_W{1'b0}};
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_rr_sum = {1'b0, r_rr_ptr} + (PTR_W + 1)'(i);
      if (w_rr_sum >= NV_EXT) begin
        w_rr_sum = w_rr_sum - NV_EXT;
      end else begin
        w_rr_sum = w_rr_sum;
      end
      w_rr_idx = w_rr_sum[PTR_W-1:0];
      if (!w_found && r_pending[w_rr_idx]) begin
        w_found = 1'b1;
        w_sel   = w_rr_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int             WD_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_timeout;
  logic            w_wd_expire;

  // Expiry fires in the TIMEOUT_CYC-th SERVE clock that still has no done.
  assign w_wd_expire = (r_state == S_SERVE) && !bus.done && (r_wd == WD_END);
  assign w_serve_end = bus.done || w_wd_expire;
  assign bus.timeout = r_timeout;

  // Watchdog counter (restarts for every grant) and sticky timeout flag.
  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      r_wd      <= {WD_W{1'b0}};
      r_timeout <= 1'b0;
    end else begin
      if ((r_state == S_SERVE) && !w_serve_end) begin
        r_wd <= r_wd + {{(WD_W - 1){1'b0}}, 1'b1};
      end else begin
        r_wd <= {WD_W{1'b0}};
      end
      if (w_wd_expire) begin
        r_timeout <= 1'b1;
      end else if (bus.clear_ovr) begin
        r_timeout <= 1'b0;
      end else begin
        r_timeout <= r_timeout;
      end
    end
  end
`else
  assign w_serve_end = bus.done;
`endif

  // FSM state register.
  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_state_nxt = S_ARB;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ARB: begin
        if (w_found) begin
          w_state_nxt = S_SERVE;
        end else begin
          w_state_nxt = S_MIX;
        end
      end
      S_SERVE: begin
        if (w_serve_end) begin
          w_state_nxt = S_ARB;
        end else begin
          w_state_nxt = S_SERVE;
        end
      end
      S_MIX: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM output logic: next values of the registered outputs and datapath.
  // Outputs are registered from these, so mix_latch is high exactly while in MIX.
  always_comb begin
    w_pending_nxt = r_pending;
    w_rr_nxt      = r_rr_ptr;
    w_sel_nxt     = r_sel;
    w_grant_nxt   = r_grant;
    w_strobe_nxt  = 1'b0;
    w_mix_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_tick) begin
          w_pending_nxt = bus.req;
          w_strobe_nxt  = 1'b1;
        end else begin
          w_pending_nxt = r_pending;
        end
      end
      S_ARB: begin
        if (w_found) begin
          w_grant_nxt = ONE_HOT0 << w_sel;
          w_sel_nxt   = w_sel;
        end else begin
          w_grant_nxt = {NUM_VOICES{1'b0}};
          w_mix_nxt   = 1'b1;
        end
      end
      S_SERVE: begin
        if (w_serve_end) begin
          w_grant_nxt          = {NUM_VOICES{1'b0}};
          w_pending_nxt[r_sel] = 1'b0;
        end else begin
          w_grant_nxt = r_grant;
        end
      end
      S_MIX: begin
        if (r_rr_ptr == PTR_LAST) begin
          w_rr_nxt = {PTR_W{1'b0}};
        end else begin
          w_rr_nxt = r_rr_ptr + {{(PTR_W - 1){1'b0}}, 1'b1};
        end
      end
      default: begin
        w_grant_nxt = {NUM_VOICES{1'b0}};
      end
    endcase

    // A tick while a frame is in flight is dropped; setting beats clearing.
    if (w_tick && (r_state != S_IDLE)) begin
      w_overrun_nxt = 1'b1;
    end else if (bus.clear_ovr) begin
      w_overrun_nxt = 1'b0;
    end else begin
      w_overrun_nxt = r_overrun;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge MHz10 or posedge rst) begin
    if (rst) begin
      r_pending     <= {NUM_VOICES{1'b0}};
      r_rr_ptr      <= {PTR_W{1'b0}};
      r_sel         <= {PTR_W{1'b0}};
      r_grant       <= {NUM_VOICES{1'b0}};
      r_samp_strobe <= 1'b0;
      r_mix_latch   <= 1'b0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_pending     <= w_pending_nxt;
      r_rr_ptr      <= w_rr_nxt;
      r_sel         <= w_sel_nxt;
      r_grant       <= w_grant_nxt;
      r_samp_strobe <= w_strobe_nxt;
      r_mix_latch   <= w_mix_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_overrun     <= w_overrun_nxt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.samp_strobe = r_samp_strobe;
  assign bus.mix_latch   = r_mix_latch;
  assign bus.busy        = r_busy;
  assign bus.overrun     = r_overrun;

endmodule
